// File: rtl/duck_hit_if.sv
// Hit report channel between the hit detector and the duck logic.
// The detector drives the report; the duck logic returns hit_ack.
interface duck_hit_if;
    logic       hit_valid;
    logic       hit_ack;
    logic [9:0] hit_x;
    logic [9:0] hit_y;
    logic [7:0] score;
    logic       busy;

    modport master (
        output hit_valid, hit_x, hit_y, score, busy,
        input  hit_ack
    );

    modport slave (
        input  hit_valid, hit_x, hit_y, score, busy,
        output hit_ack
    );
endinterface

// File: rtl/duck_hit_detector.sv
// Counts duck/bullet pixel overlap per VGA frame, declares a hit at frame end
// and reports it with a valid/ack handshake, followed by a frame cooldown.
module duck_hit_detector #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        duck_draw,
    input  logic        shot_drawer,
    duck_hit_if.master  hit_if
);
    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_REPORT   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    localparam logic [9:0] H_END   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [7:0] MIN_CNT = 8'(MIN_OVERLAP);
    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_FRAMES);

    logic [1:0] state;
    logic [7:0] overlap_cnt;
    logic [7:0] cnt_next;
    logic [7:0] cd_cnt;
    logic [9:0] first_x;
    logic [9:0] first_y;
    logic       seen;
    logic       active;
    logic       overlap;
    logic       frame_end;

    always_comb begin
        active    = (hcount < H_ACT) && (vcount < V_ACT);
        overlap   = active && duck_draw && shot_drawer;
        frame_end = (hcount == H_END) && (vcount == V_END);
        cnt_next  = overlap_cnt;
        if (overlap && overlap_cnt != 8'hFF)
            cnt_next = overlap_cnt + 8'd1;
    end

    assign hit_if.busy = (state != S_SCAN);

    always_ff @(posedge vga_clk) begin
        if (!reset) begin
            state            <= S_SCAN;
            hit_if.hit_valid <= 1'b0;
            hit_if.hit_x     <= '0;
            hit_if.hit_y     <= '0;
            hit_if.score     <= '0;
            overlap_cnt      <= '0;
            seen             <= 1'b0;
            cd_cnt           <= '0;
            first_x          <= '0;
            first_y          <= '0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (frame_end) begin
                        overlap_cnt <= '0;
                        seen        <= 1'b0;
                        if (cnt_next >= MIN_CNT) begin
                            state            <= S_REPORT;
                            hit_if.hit_valid <= 1'b1;
                            // the frame-end pixel itself may be the first overlap
                            hit_if.hit_x     <= seen ? first_x : hcount;
                            hit_if.hit_y     <= seen ? first_y : vcount;
                            if (hit_if.score != 8'hFF)
                                hit_if.score <= hit_if.score + 8'd1;
                        end
                    end else begin
                        overlap_cnt <= cnt_next;
                        if (overlap && !seen) begin
                            first_x <= hcount;
                            first_y <= vcount;
                            seen    <= 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (hit_if.hit_ack) begin
                        hit_if.hit_valid <= 1'b0;
                        cd_cnt           <= CD_LOAD;
                        state            <= (CD_LOAD == 8'd0) ? S_SCAN : S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (frame_end) begin
                        cd_cnt <= cd_cnt - 8'd1;
                        if (cd_cnt <= 8'd1)
                            state <= S_SCAN;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_duck_hit_detector.sv
// Scoreboard bench: stimulus pushes expected hit reports, per-DUT monitors pop
// and compare on each rising hit_valid. Two instances cover both cooldown paths.
module tb_duck_hit_detector;
    typedef struct {
        int x;
        int y;
        int score;
    } exp_t;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [9:0] hcount  = 10'd700;
    logic [9:0] vcount  = 10'd500;
    logic       duck    = 1'b0;
    logic       shot    = 1'b0;
    logic       en_a    = 1'b0;
    logic       en_b    = 1'b0;
    logic       prev_a  = 1'b0;
    logic       prev_b  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    duck_hit_if if_a ();
    duck_hit_if if_b ();

    always #5 vga_clk = ~vga_clk;

    duck_hit_detector #(
        .H_TOTAL(800), .V_TOTAL(525), .H_ACTIVE(640), .V_ACTIVE(480),
        .MIN_OVERLAP(4), .COOLDOWN_FRAMES(2)
    ) dut_a (
        .vga_clk(vga_clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .duck_draw(duck & en_a), .shot_drawer(shot & en_a), .hit_if(if_a.master)
    );

    duck_hit_detector #(
        .H_TOTAL(800), .V_TOTAL(525), .H_ACTIVE(640), .V_ACTIVE(480),
        .MIN_OVERLAP(2), .COOLDOWN_FRAMES(0)
    ) dut_b (
        .vga_clk(vga_clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .duck_draw(duck & en_b), .shot_drawer(shot & en_b), .hit_if(if_b.master)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge vga_clk) begin
        if (if_a.hit_valid && !prev_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_hit", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_hit_x", int'(if_a.hit_x), e.x);
                chk("a_hit_y", int'(if_a.hit_y), e.y);
                chk("a_score", int'(if_a.score), e.score);
                chk("a_busy", int'(if_a.busy), 1);
            end
        end
        prev_a <= if_a.hit_valid;
    end

    always @(negedge vga_clk) begin
        if (if_b.hit_valid && !prev_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_hit", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_hit_x", int'(if_b.hit_x), e.x);
                chk("b_hit_y", int'(if_b.hit_y), e.y);
                chk("b_score", int'(if_b.score), e.score);
                chk("b_busy", int'(if_b.busy), 1);
            end
        end
        prev_b <= if_b.hit_valid;
    end

    task automatic pix(input int h, input int v, input logic d, input logic s);
        hcount = 10'(h);
        vcount = 10'(v);
        duck   = d;
        shot   = s;
        @(posedge vga_clk);
        #1;
        hcount = 10'd700;
        vcount = 10'd500;
        duck   = 1'b0;
        shot   = 1'b0;
    endtask

    task automatic frame_end();
        pix(799, 524, 1'b0, 1'b0);
    endtask

    task automatic run(input int h, input int v, input int n);
        for (int i = 0; i < n; i++)
            pix(h + i, v, 1'b1, 1'b1);
    endtask

    task automatic push_a(input int x, input int y, input int sc);
        exp_t e;
        e.x = x; e.y = y; e.score = sc;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int x, input int y, input int sc);
        exp_t e;
        e.x = x; e.y = y; e.score = sc;
        q_b.push_back(e);
    endtask

    task automatic ack_a(input int cycles);
        if_a.hit_ack = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge vga_clk);
            #1;
            if (i == 0) chk("a_valid_after_ack", int'(if_a.hit_valid), 0);
        end
        if_a.hit_ack = 1'b0;
    endtask

    task automatic ack_b();
        if_b.hit_ack = 1'b1;
        @(posedge vga_clk);
        #1;
        if_b.hit_ack = 1'b0;
    endtask

    initial begin
        if_a.hit_ack = 1'b0;
        if_b.hit_ack = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_valid", int'(if_a.hit_valid), 0);
        chk("rst_score", int'(if_a.score), 0);
        chk("rst_busy", int'(if_a.busy), 0);
        chk("rst_x", int'(if_a.hit_x), 0);
        chk("rst_b_score", int'(if_b.score), 0);
        reset = 1'b1;
        en_a  = 1'b1;

        // single hit, 5 overlaps from (300,200)
        run(300, 200, 5);
        push_a(300, 200, 1);
        frame_end();
        chk("single_valid", int'(if_a.hit_valid), 1);
        chk("single_busy", int'(if_a.busy), 1);

        // no ack for 10 frames: report held, new overlaps ignored
        for (int f = 0; f < 10; f++) begin
            run(10, 10 + f, 5);
            frame_end();
            chk("hold_valid", int'(if_a.hit_valid), 1);
        end
        chk("hold_x", int'(if_a.hit_x), 300);
        chk("hold_score", int'(if_a.score), 1);

        // multi-cycle ack, then two cooldown frames with overlap that must not count
        ack_a(3);
        chk("cd_busy", int'(if_a.busy), 1);
        run(50, 60, 5);
        frame_end();
        chk("cd1_valid", int'(if_a.hit_valid), 0);
        chk("cd1_busy", int'(if_a.busy), 1);
        run(50, 60, 5);
        frame_end();
        chk("cd2_valid", int'(if_a.hit_valid), 0);
        chk("cd2_busy", int'(if_a.busy), 0);
        run(50, 60, 5);
        push_a(50, 60, 2);
        frame_end();
        chk("cd3_valid", int'(if_a.hit_valid), 1);
        ack_a(1);
        frame_end();
        frame_end();
        chk("back_to_scan", int'(if_a.busy), 0);

        // below threshold, then a 1-pixel frame proves the count was cleared
        run(100, 100, 3);
        frame_end();
        chk("below_valid", int'(if_a.hit_valid), 0);
        run(100, 101, 1);
        frame_end();
        chk("clean_count_valid", int'(if_a.hit_valid), 0);
        chk("below_score", int'(if_a.score), 2);

        // overlaps only in blanking or out of range
        run(700, 100, 5);
        run(100, 490, 5);
        run(1000, 524, 3);
        frame_end();
        chk("blank_valid", int'(if_a.hit_valid), 0);

        // reset mid-REPORT with score 3
        run(20, 30, 4);
        push_a(20, 30, 3);
        frame_end();
        chk("pre_rst_score", int'(if_a.score), 3);
        reset = 1'b0;
        @(posedge vga_clk);
        #1;
        reset = 1'b1;
        chk("midrst_valid", int'(if_a.hit_valid), 0);
        chk("midrst_score", int'(if_a.score), 0);
        chk("midrst_busy", int'(if_a.busy), 0);
        chk("midrst_x", int'(if_a.hit_x), 0);
        chk("midrst_y", int'(if_a.hit_y), 0);
        run(40, 41, 4);
        push_a(40, 41, 1);
        frame_end();
        ack_a(1);
        frame_end();
        frame_end();
        en_a = 1'b0;

        // edge pixels on the MIN_OVERLAP=2 / no-cooldown instance
        en_b = 1'b1;
        run(0, 0, 1);
        run(639, 479, 1);
        push_b(0, 0, 1);
        frame_end();
        chk("edge_valid", int'(if_b.hit_valid), 1);
        ack_b();
        chk("nocd_valid", int'(if_b.hit_valid), 0);
        chk("nocd_busy", int'(if_b.busy), 0);
        run(639, 479, 1);
        frame_end();
        chk("b_single_px", int'(if_b.hit_valid), 0);

        // score saturation: 256 further hits
        for (int k = 0; k < 256; k++) begin
            run(5, 5, 2);
            push_b(5, 5, (k + 2 > 255) ? 255 : k + 2);
            frame_end();
            ack_b();
        end
        chk("sat_score", int'(if_b.score), 255);

        repeat (4) @(posedge vga_clk);
        #1;
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
